// File: rtl/traffic_light_ctrl_module_pkg.sv
// Shared definitions for the two-road traffic light sequencer.
// The package holds the phase encodings, the lamp patterns, the per-phase lamp
// decode and the fixed phase order. It has no ports.
package traffic_light_ctrl_module_pkg;

    typedef enum logic [1:0] {
        ST_NS_G = 2'd0,
        ST_NS_Y = 2'd1,
        ST_EW_G = 2'd2,
        ST_EW_Y = 2'd3
    } state_t;

    // Lamp sets are {R,Y,G}, with 1 meaning the lamp is on.
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
    } lamps_t;

    // Each phase keeps one road red, so both roads can never be non-red at once.
    function automatic lamps_t lamps_for(input state_t s);
        lamps_t l;
        case (s)
            ST_NS_G: l = '{ns: LAMP_G, ew: LAMP_R};
            ST_NS_Y: l = '{ns: LAMP_Y, ew: LAMP_R};
            ST_EW_G: l = '{ns: LAMP_R, ew: LAMP_G};
            default: l = '{ns: LAMP_R, ew: LAMP_Y};
        endcase
        return l;
    endfunction

    function automatic state_t next_state(input state_t s);
        state_t n;
        case (s)
            ST_NS_G: n = ST_NS_Y;
            ST_NS_Y: n = ST_EW_G;
            ST_EW_G: n = ST_EW_Y;
            default: n = ST_NS_G;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_module_tick_gen.sv
// One-second tick prescaler.
// Ports:
//   CLK   in  system clock
//   RSTn  in  asynchronous active-low reset
//   En    in  1 = prescaler counts; 0 = prescaler is frozen
//   Clr   in  1 = prescaler is forced to 0 (wins over En)
//   Tick  out 1 for the single cycle the count equals TICK_DIV-1 while counting
module traffic_light_ctrl_module_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic En,
    input  logic Clr,
    output logic Tick
);

    localparam int             CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // Tick is combinational so the top can react in the same cycle. A clear
    // takes priority over counting, so it also suppresses the tick.
    assign Tick = En & ~Clr & (count == LAST);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples values from before the clock edge.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            count <= '0;
        end else if (Clr) begin
            count <= '0;
        end else if (En) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/traffic_light_ctrl_module.sv
// Two-road (NS/EW) traffic light sequencer with a per-phase seconds countdown.
// Ports:
//   CLK          in   system clock
//   RSTn         in   asynchronous active-low reset
//   Hold         in   1 = freeze prescaler, countdown and phase
//   Night_Mode   in   1 = both roads flash yellow; overrides Hold
//   NS_Light     out  {R,Y,G} lamps for north-south
//   EW_Light     out  {R,Y,G} lamps for east-west
//   Number_Data  out  remaining seconds of the current phase, binary 0..99
//   Phase_Done   out  1-cycle pulse on every phase change
module traffic_light_ctrl_module
    import traffic_light_ctrl_module_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int GREEN_TIME  = 25,
    parameter int YELLOW_TIME = 3
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Hold,
    input  logic       Night_Mode,
    output logic [2:0] NS_Light,
    output logic [2:0] EW_Light,
    output logic [7:0] Number_Data,
    output logic       Phase_Done
);

    localparam logic [7:0] GREEN_LEN  = 8'(GREEN_TIME);
    localparam logic [7:0] YELLOW_LEN = 8'(YELLOW_TIME);

    function automatic logic [7:0] phase_len(input state_t s);
        return (s == ST_NS_G || s == ST_EW_G) ? GREEN_LEN : YELLOW_LEN;
    endfunction

    state_t state;
    state_t state_nxt;
    logic   night_q;     // Night_Mode delayed by one cycle, for edge detection
    logic   flash;
    logic   flash_nxt;
    logic   tick;
    logic   en;
    logic   clr;

    // Night mode keeps the prescaler running even under Hold; either edge of
    // Night_Mode restarts the prescaler so a new mode starts on a full second.
    assign en  = ~Hold | Night_Mode;
    assign clr = Night_Mode ^ night_q;

    traffic_light_ctrl_module_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .CLK  (CLK),
        .RSTn (RSTn),
        .En   (en),
        .Clr  (clr),
        .Tick (tick)
    );

    // NOTE: every variable is given a value on every path through always_comb,
    // otherwise synthesis would infer a latch to hold the old value.
    always_comb begin
        state_nxt = next_state(state);
        flash_nxt = 1'b1;                    // entering night mode starts lit
        if (night_q) begin
            flash_nxt = tick ? ~flash : flash;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state       <= ST_NS_G;
            Number_Data <= GREEN_LEN;
            NS_Light    <= LAMP_G;
            EW_Light    <= LAMP_R;
            Phase_Done  <= 1'b0;
            flash       <= 1'b0;
            night_q     <= 1'b0;
        end else begin
            night_q    <= Night_Mode;
            Phase_Done <= 1'b0;
            if (Night_Mode) begin
                // The phase register is left untouched; night exit restarts it.
                flash       <= flash_nxt;
                Number_Data <= 8'd0;
                NS_Light    <= flash_nxt ? LAMP_Y : LAMP_OFF;
                EW_Light    <= flash_nxt ? LAMP_Y : LAMP_OFF;
            end else if (night_q) begin
                // Leaving night mode restarts the cycle silently (no Phase_Done).
                state                  <= ST_NS_G;
                Number_Data            <= GREEN_LEN;
                {NS_Light, EW_Light}   <= lamps_for(ST_NS_G);
                flash                  <= 1'b0;
            end else if (!Hold && tick) begin
                if (Number_Data > 8'd1) begin
                    Number_Data <= Number_Data - 8'd1;
                end else begin
                    state                <= state_nxt;
                    Number_Data          <= phase_len(state_nxt);
                    {NS_Light, EW_Light} <= lamps_for(state_nxt);
                    Phase_Done           <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl_module.sv
// Self-checking bench for traffic_light_ctrl_module with TICK_DIV=4,
// GREEN_TIME=5, YELLOW_TIME=2. A table of {inputs, run length, expected
// outputs} records is replayed cycle by cycle; reset behaviour and the wait
// for EW_YELLOW are written out by hand.
module tb_traffic_light_ctrl_module;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b1;
    logic       Hold = 1'b0;
    logic       Night_Mode = 1'b0;
    logic [2:0] NS_Light;
    logic [2:0] EW_Light;
    logic [7:0] Number_Data;
    logic       Phase_Done;

    traffic_light_ctrl_module #(
        .TICK_DIV    (4),
        .GREEN_TIME  (5),
        .YELLOW_TIME (2)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .Hold        (Hold),
        .Night_Mode  (Night_Mode),
        .NS_Light    (NS_Light),
        .EW_Light    (EW_Light),
        .Number_Data (Number_Data),
        .Phase_Done  (Phase_Done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       hold;
        logic       night;
        int         n;       // cycles this record lasts
        logic [2:0] ns;
        logic [2:0] ew;
        logic [7:0] num;
        logic       pulse;   // Phase_Done expected on the first cycle only
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   pulses_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic h, input logic nm, input int n, input logic [2:0] ns,
                       input logic [2:0] ew, input logic [7:0] num, input logic p);
        vec_t v;
        v.hold = h; v.night = nm; v.n = n; v.ns = ns; v.ew = ew; v.num = num; v.pulse = p;
        tbl.push_back(v);
    endtask

    // Advance one clock edge and sample 1 time unit after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " ns"},   32'(NS_Light),    32'(3'b001));
        check({tag, " ew"},   32'(EW_Light),    32'(3'b100));
        check({tag, " num"},  32'(Number_Data), 32'd5);
        check({tag, " done"}, 32'(Phase_Done),  32'd0);
    endtask

    task automatic apply_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                Hold = tbl[i].hold;
                Night_Mode = tbl[i].night;
                step();
                if (Phase_Done === 1'b1) pulses_seen++;
                check($sformatf("v%0d.%0d ns", i, c),   32'(NS_Light),    32'(tbl[i].ns));
                check($sformatf("v%0d.%0d ew", i, c),   32'(EW_Light),    32'(tbl[i].ew));
                check($sformatf("v%0d.%0d num", i, c),  32'(Number_Data), 32'(tbl[i].num));
                check($sformatf("v%0d.%0d done", i, c), 32'(Phase_Done),
                      32'(tbl[i].pulse && c == 0));
                if (!tbl[i].night) begin
                    check($sformatf("v%0d.%0d one_road", i, c),
                          32'((NS_Light != 3'b100) && (EW_Light != 3'b100)), 32'd0);
                end
            end
        end
        Hold = 1'b0;
        Night_Mode = 1'b0;
    endtask

    initial begin
        #5000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Free run from reset: one full 56-cycle period (records 0..17).
        add(0, 0, 3, 3'b001, 3'b100, 8'd5, 0);   // 0
        add(0, 0, 4, 3'b001, 3'b100, 8'd4, 0);   // 1
        add(0, 0, 4, 3'b001, 3'b100, 8'd3, 0);   // 2
        add(0, 0, 4, 3'b001, 3'b100, 8'd2, 0);   // 3
        add(0, 0, 4, 3'b001, 3'b100, 8'd1, 0);   // 4
        add(0, 0, 1, 3'b010, 3'b100, 8'd2, 1);   // 5  NS_YELLOW
        add(0, 0, 3, 3'b010, 3'b100, 8'd2, 0);   // 6
        add(0, 0, 4, 3'b010, 3'b100, 8'd1, 0);   // 7
        add(0, 0, 1, 3'b100, 3'b001, 8'd5, 1);   // 8  EW_GREEN
        add(0, 0, 3, 3'b100, 3'b001, 8'd5, 0);   // 9
        add(0, 0, 4, 3'b100, 3'b001, 8'd4, 0);   // 10
        add(0, 0, 4, 3'b100, 3'b001, 8'd3, 0);   // 11
        add(0, 0, 4, 3'b100, 3'b001, 8'd2, 0);   // 12
        add(0, 0, 4, 3'b100, 3'b001, 8'd1, 0);   // 13
        add(0, 0, 1, 3'b100, 3'b010, 8'd2, 1);   // 14 EW_YELLOW
        add(0, 0, 3, 3'b100, 3'b010, 8'd2, 0);   // 15
        add(0, 0, 4, 3'b100, 3'b010, 8'd1, 0);   // 16
        add(0, 0, 1, 3'b001, 3'b100, 8'd5, 1);   // 17 back to NS_GREEN
        add(0, 0, 3, 3'b001, 3'b100, 8'd5, 0);   // 18
        add(0, 0, 4, 3'b001, 3'b100, 8'd4, 0);   // 19
        add(0, 0, 3, 3'b001, 3'b100, 8'd3, 0);   // 20 ends with prescaler = 2
        // Hold for 10 cycles mid-count, then decrement 2 cycles after release.
        add(1, 0, 10, 3'b001, 3'b100, 8'd3, 0);  // 21
        add(0, 0, 1, 3'b001, 3'b100, 8'd3, 0);   // 22
        add(0, 0, 4, 3'b001, 3'b100, 8'd2, 0);   // 23
        add(0, 0, 4, 3'b001, 3'b100, 8'd1, 0);   // 24 a tick is due next cycle
        // Night mode for 20 cycles; entry clears the due tick, so no phase change.
        add(0, 1, 4, 3'b010, 3'b010, 8'd0, 0);   // 25
        add(0, 1, 4, 3'b000, 3'b000, 8'd0, 0);   // 26
        add(0, 1, 4, 3'b010, 3'b010, 8'd0, 0);   // 27
        add(0, 1, 4, 3'b000, 3'b000, 8'd0, 0);   // 28
        add(0, 1, 4, 3'b010, 3'b010, 8'd0, 0);   // 29
        add(0, 0, 1, 3'b001, 3'b100, 8'd5, 0);   // 30 exit: NS_GREEN, no pulse
        add(0, 0, 3, 3'b001, 3'b100, 8'd5, 0);   // 31
        add(0, 0, 4, 3'b001, 3'b100, 8'd4, 0);   // 32
        // Hold and Night_Mode together: night flashing still runs.
        add(1, 1, 4, 3'b010, 3'b010, 8'd0, 0);   // 33
        add(1, 1, 4, 3'b000, 3'b000, 8'd0, 0);   // 34
        add(1, 1, 4, 3'b010, 3'b010, 8'd0, 0);   // 35
        add(0, 0, 1, 3'b001, 3'b100, 8'd5, 0);   // 36

        // Initial reset, released mid-cycle.
        #1 RSTn = 1'b0;
        repeat (3) step();
        check_reset_values("reset");
        #2 RSTn = 1'b1;

        apply_range(0, 17);
        check("pulses_per_period", 32'(pulses_seen), 32'd4);
        apply_range(18, 36);

        // Run to EW_YELLOW, then reset asynchronously between clock edges.
        begin
            bit found = 1'b0;
            for (int k = 0; k < 100; k++) begin
                step();
                if (EW_Light === 3'b010) begin
                    found = 1'b1;
                    break;
                end
            end
            check("reach_ew_yellow", 32'(found), 32'd1);
        end
        check("ew_yellow ns", 32'(NS_Light), 32'(3'b100));
        check("ew_yellow num", 32'(Number_Data), 32'd2);
        step();
        #2 RSTn = 1'b0;
        #1;
        check_reset_values("async_reset");
        #2 RSTn = 1'b1;

        pulses_seen = 0;
        apply_range(0, 17);
        check("pulses_after_reset", 32'(pulses_seen), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
